// File: rtl/pc_seq_if.sv
// pc_seq_if: groups the pc_sequencer control inputs and status outputs.
// master = jump control / testbench side, slave = pc_sequencer.
interface pc_seq_if #(
    parameter int ADDR_W = 8,
    parameter int FLAG_W = 4
);
    logic              stall;
    logic              pc_mux_sel;
    logic [ADDR_W-1:0] jmp_loc;
    logic [4:0]        ins_opcode;
    logic [FLAG_W-1:0] flag_ex;
    logic              irq_req;
    logic [ADDR_W-1:0] pc;
    logic              interrupt;
    logic              irq_ack;
    logic [FLAG_W-1:0] flag_restore;
    logic              flag_restore_valid;
    logic              in_isr;
    logic              ret_underflow;

    modport master (
        output stall, pc_mux_sel, jmp_loc, ins_opcode, flag_ex, irq_req,
        input  pc, interrupt, irq_ack, flag_restore, flag_restore_valid,
               in_isr, ret_underflow
    );

    modport slave (
        input  stall, pc_mux_sel, jmp_loc, ins_opcode, flag_ex, irq_req,
        output pc, interrupt, irq_ack, flag_restore, flag_restore_valid,
               in_isr, ret_underflow
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter plus interrupt entry/return context unit.
// Optional macro IRQ_NEST_EN: when defined, a STACK_DEPTH-entry LIFO context
// stack allows nested interrupts; otherwise a single context register is used
// and requests during an ISR wait until RETI returns to RUN.
module pc_sequencer #(
    parameter int                ADDR_W      = 8,
    parameter int                FLAG_W      = 4,
    parameter logic [ADDR_W-1:0] ISR_VEC     = 8'hF0,
    parameter int                STACK_DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    pc_seq_if.slave bus
);
`ifdef IRQ_NEST_EN
    localparam int MAX_DEPTH = STACK_DEPTH;
`else
    // Single context register; STACK_DEPTH has no effect in this build.
    localparam int MAX_DEPTH = (STACK_DEPTH > 0) ? 1 : 1;
`endif
    localparam int                ENT_W  = ADDR_W + FLAG_W;
    localparam int                DW     = $clog2(MAX_DEPTH + 1);
    localparam logic [DW-1:0]     D_ONE  = 1;
    localparam logic [DW-1:0]     D_MAX  = DW'(MAX_DEPTH);
    localparam logic [ADDR_W-1:0] A_ONE  = 1;
    localparam logic [4:0]        OP_RETI = 5'b10000;

    typedef enum logic {RUN, ISR} state_t;

    state_t                        state_q, state_d;
    logic [ADDR_W-1:0]             pc_q, pc_d;
    logic [DW-1:0]                 depth_q, depth_d;
    logic [MAX_DEPTH-1:0][ENT_W-1:0] stack_q, stack_d;
    logic                          irq_q, pend_q, pend_d;
    logic                          int_q, int_d;
    logic [FLAG_W-1:0]             frest_q, frest_d;
    logic                          frv_q, frv_d;
    logic                          uf_q, uf_d;

    logic              rise, is_reti, entry_ok, do_pop, do_push;
    logic [ADDR_W-1:0] pc_inc, ret_addr;

    assign rise     = bus.irq_req & ~irq_q;
    assign is_reti  = (bus.ins_opcode == OP_RETI);
    assign pc_inc   = pc_q + A_ONE;
    assign ret_addr = bus.pc_mux_sel ? bus.jmp_loc : pc_inc;
`ifdef IRQ_NEST_EN
    assign entry_ok = (depth_q < D_MAX);
`else
    assign entry_ok = (state_q == RUN);
`endif
    // RETI outranks entry; an edge seen this cycle is taken immediately.
    assign do_pop  = ~bus.stall & is_reti & (depth_q != '0);
    assign do_push = ~bus.stall & ~do_pop & (pend_q | rise) & entry_ok;

    // Next-state: PC selection, LIFO stack, strobes and pending request.
    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        stack_d = stack_q;
        frest_d = frest_q;
        frv_d   = 1'b0;
        int_d   = 1'b0;
        uf_d    = uf_q;
        // A push that consumes the pending request keeps a fresh edge, if any.
        pend_d  = do_push ? (pend_q & rise) : (pend_q | rise);
        if (!bus.stall) begin
            if (do_pop) begin
                pc_d    = stack_q[0][ENT_W-1:FLAG_W];
                frest_d = stack_q[0][FLAG_W-1:0];
                frv_d   = 1'b1;
                depth_d = depth_q - D_ONE;
                for (int i = 0; i < MAX_DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
                stack_d[MAX_DEPTH-1] = '0;
            end else if (do_push) begin
                pc_d    = ISR_VEC;
                int_d   = 1'b1;
                depth_d = depth_q + D_ONE;
                for (int i = MAX_DEPTH - 1; i > 0; i--) stack_d[i] = stack_q[i-1];
                stack_d[0] = {ret_addr, bus.flag_ex};
            end else begin
                pc_d = bus.pc_mux_sel ? bus.jmp_loc : pc_inc;
                if (is_reti) uf_d = 1'b1;
            end
        end
    end

    // FSM next state: RUN while no context saved, ISR otherwise.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (do_push) state_d = ISR;
            ISR:     if (do_pop && depth_q == D_ONE) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= '0;
            depth_q <= '0;
            stack_q <= '0;
            irq_q   <= 1'b0;
            pend_q  <= 1'b0;
            int_q   <= 1'b0;
            frest_q <= '0;
            frv_q   <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
            stack_q <= stack_d;
            irq_q   <= bus.irq_req;
            pend_q  <= pend_d;
            int_q   <= int_d;
            frest_q <= frest_d;
            frv_q   <= frv_d;
            uf_q    <= uf_d;
        end
    end

    assign bus.pc                 = pc_q;
    assign bus.interrupt          = int_q;
    assign bus.irq_ack            = int_q;
    assign bus.flag_restore       = frest_q;
    assign bus.flag_restore_valid = frv_q;
    assign bus.in_isr             = (state_q == ISR);
    assign bus.ret_underflow      = uf_q;
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and interrupt-context unit for the 8-bit-address, 20-bit-instruction processor.
- Consumes the jump location and PC mux select from the jump control logic; supplies the fetch address.
- Generates the `interrupt` strobe back to the jump control logic.
- Saves return address and flags on interrupt entry; restores both when RETI (opcode 5'b10000) executes.

Parameters:
ADDR_W, 8, program address width
FLAG_W, 4, execution flag width (bit1 = zero, bit0 = carry)
ISR_VEC, 8'hF0, interrupt service routine entry address
STACK_DEPTH, 4, context stack entries (used only with nesting enabled)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  freeze PC, stack and FSM this cycle
pc_mux_sel  in  1  take jmp_loc instead of pc+1
jmp_loc  in  ADDR_W  jump target
ins_opcode  in  5  ins[19:15] of the current instruction
flag_ex  in  FLAG_W  current execution flags
irq_req  in  1  external interrupt request, level
pc  out  ADDR_W  fetch address
interrupt  out  1  one-cycle interrupt-entry strobe to jump control
irq_ack  out  1  one-cycle acknowledge to requester
flag_restore  out  FLAG_W  flags popped by RETI
flag_restore_valid  out  1  one-cycle strobe: load flag_restore into flag register
in_isr  out  1  context depth > 0
ret_underflow  out  1  sticky: RETI executed with empty stack

Behaviour:
- Reset (synchronous, high) clears all state:
  - pc=0, interrupt=0, irq_ack=0, flag_restore=0, flag_restore_valid=0, in_isr=0, ret_underflow=0.
  - Stack depth=0, irq_pending=0, FSM=RUN.
  - Reset asserted mid-ISR discards all saved context.
- All outputs are registered. PC changes one clock after the deciding inputs.
- irq_req is edge-detected against a registered copy. A rising edge sets irq_pending, including during stall. irq_pending clears on entry.
- Next-PC selection (not stalled), highest priority first:
  1. RETI: ins_opcode==5'b10000 and depth>0. Pop; pc <= saved address; flag_restore <= saved flags; flag_restore_valid=1 for one cycle; depth-1.
  2. Interrupt entry: irq_pending and entry allowed. Push {ret, flag_ex}, where ret = jmp_loc if pc_mux_sel else pc+1. Then pc <= ISR_VEC; interrupt=1 and irq_ack=1 for one cycle; depth+1.
  3. pc_mux_sel: pc <= jmp_loc.
  4. Otherwise: pc <= pc+1, wrapping 8'hFF to 8'h00.
- RETI with depth==0: treated as a normal instruction (rule 3/4); ret_underflow set until reset.
- RETI and irq_pending in the same cycle: RETI wins. Entry is evaluated from the next cycle.
- stall=1: pc, stack, depth and ret_underflow hold. No strobes. Pending requests are retained.
- FSM states:
  - RUN (depth 0): entry goes to ISR.
  - ISR (depth>0): a RETI that brings depth to 0 goes to RUN.
  - in_isr = (state==ISR).
- Entry allowed:
  - Without nesting: state==RUN only.
  - With nesting: depth<STACK_DEPTH.
- A request arriving when entry is not allowed stays pending and is taken at the first allowed cycle.

Optional Feature:
Macro IRQ_NEST_EN.
- Defined: context stack of STACK_DEPTH entries (ADDR_W+FLAG_W bits each). Nested interrupts are accepted while depth<STACK_DEPTH; at full depth the request stays pending. Pops are LIFO.
- Undefined: single context register (depth 0/1). STACK_DEPTH is ignored. Requests during ISR stay pending until RETI returns to RUN.

Test Plan:
- Reset then 3 free cycles: pc 00→01→02→03. Preload pc=FF via pc_mux_sel/jmp_loc=FF; next free cycle: pc=00.
- At pc=12, pulse irq_req with flag_ex=4'b0011: next cycle pc=F0, interrupt=1 and irq_ack=1 for one cycle, in_isr=1. Later RETI: pc=13, flag_restore=0011, flag_restore_valid one cycle, in_isr=0.
- irq edge with pc_mux_sel=1, jmp_loc=40: pc=F0. After RETI: pc=40.
- stall held 3 cycles around an irq_req edge: pc frozen, no strobes. First unstalled cycle: pc=F0.
- RETI at depth 0, pc=20: pc=21, ret_underflow=1 and remains 1 until reset. Reset asserted inside an ISR: pc=00, in_isr=0.
- Nesting:
  - IRQ_NEST_EN defined: second irq edge inside the ISR at pc=F3 gives pc=F0. Two RETIs return to F4, then the original address.
  - IRQ_NEST_EN undefined: second request waits; taken the cycle after RETI (pc=F0 again).
